dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and the 256-bit line memory.
- Acts as the initiator on the memory line interface (enable/write/address/data out, ack/data in); the memory is the responder.
- Serves CPU word hits combinationally; stalls the CPU while a miss performs an optional dirty-line writeback and then a line refill.

Parameters:
NUM_LINES, 32, number of cache lines; power of two, at least 2; INDEX_W = log2(NUM_LINES)
LINE_BYTES, 32, fixed line size of 256 bits; not overridable; OFFSET_W = 5
TAG_W, 27-INDEX_W, tag width; 22 at default

Ports:
clk_i  in  1  single clock; all state changes on the rising edge
rst_i  in  1  reset; asynchronous, active-low
p1_addr_i  in  32  CPU byte address; bits [1:0] ignored
p1_data_i  in  32  CPU store data
p1_MemRead_i  in  1  CPU load request
p1_MemWrite_i  in  1  CPU store request; wins if both requests are asserted
p1_data_o  out  32  load data; valid when a request is asserted and p1_stall_o=0
p1_stall_o  out  1  CPU must hold its request while this is 1
mem_enable_o  out  1  memory transaction request
mem_write_o  out  1  1 = line write, 0 = line read
mem_addr_o  out  32  line address; bits [4:0] always 0
mem_data_o  out  256  writeback line data
mem_ack_i  in  1  one-cycle completion pulse from memory
mem_data_i  in  256  refill data; valid in the cycle after mem_ack_i

Behaviour:
- Address split: word = addr[4:2]; index = addr[INDEX_W+4:5]; tag = addr[31:INDEX_W+5].
- Storage per line: valid, dirty, tag[TAG_W], data[256].
- Reset (asynchronous, active-low):
  - state = IDLE.
  - All valid and dirty bits cleared.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, p1_data_o = 0.
  - p1_stall_o = 0 whenever no request is asserted.
  - Reset mid-transaction abandons it; no line is updated.
- hit = req & valid[index] & (tag[index] == addr tag), where req = p1_MemRead_i | p1_MemWrite_i.
- IDLE:
  - Read hit: p1_data_o = data[index] word selected by addr[4:2], combinationally, same cycle; p1_stall_o = 0.
  - Write hit: p1_stall_o = 0; at the next edge the selected word is replaced by p1_data_i and dirty[index] is set to 1.
  - Miss: p1_stall_o = 1 combinationally in the same cycle.
  - Miss with dirty[index] = 1: next state WRITEBACK.
  - Miss with dirty[index] = 0: next state REFILL.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {stored tag, index, 5'b0}, mem_data_o = stored line.
  - These outputs are held stable until mem_ack_i.
  - On mem_ack_i go to REFILL.
- REFILL:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 5'b0}.
  - mem_write_o changes on the same edge that leaves WRITEBACK, so enable may stay high across both transactions.
  - On mem_ack_i go to FILL.
- FILL:
  - mem_enable_o = 0.
  - At this edge: line = mem_data_i, tag = request tag, valid = 1, dirty = 0.
  - Next state IDLE.
- p1_stall_o = 1 in every state other than IDLE.
- After FILL the held request replays in IDLE as a hit. A store completes through the write-hit path (write-allocate), setting dirty.
- mem_enable_o drops no later than the FILL cycle. Enable is never high in IDLE.
- An ack arriving in IDLE or FILL is ignored.
- Request changes while stalled are illegal (CPU contract). The cache latches the miss address on leaving IDLE and uses the latched address until FILL.
- Memory latency is not counted in this block; completion is signalled only by mem_ack_i.

Test Plan:
- Reset, then read 0x0000_0040 -> stall=1, one read transaction to mem_addr_o=0x40; after ack plus one cycle, line filled; data returned with stall=0 in the following IDLE cycle.
- Store 0xDEADBEEF to 0x44 (hit) -> no stall, no memory traffic; dirty[2]=1. A later load of 0x44 returns 0xDEADBEEF with stall=0.
- Load 0x0000_0444 (same index 2, different tag, dirty line) -> write transaction first: mem_addr_o=0x40, word1 of mem_data_o = 0xDEADBEEF. Then read transaction: mem_addr_o=0x440. Stall spans both transactions.
- Store-miss to a clean line at 0x80 -> refill only (no writeback); then the word is written and dirty[4]=1.
- Assert rst_i=0 during WRITEBACK -> immediately mem_enable_o=0, state IDLE; a subsequent load of 0x44 misses (valid cleared).
- MemRead and MemWrite both high on a hit -> treated as a store: line updated, dirty set.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache. Word hits are served
// combinationally; misses stall the CPU while an optional dirty-line writeback
// and a line refill run on the 256-bit memory interface.
module dcache_controller #(
  parameter int unsigned NUM_LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i
);

  localparam int unsigned IndexW  = $clog2(NUM_LINES);
  localparam int unsigned OffsetW = 5;
  localparam int unsigned TagW    = 32 - IndexW - OffsetW;

  typedef enum logic [1:0] {StIdle, StWriteback, StRefill, StFill} state_e;

  state_e state_q, state_d;

  // Per-line metadata and storage
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TagW-1:0]      tag_q  [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];

  // Miss address latched on leaving idle; used until the fill completes
  logic [IndexW-1:0] miss_idx_q, miss_idx_d;
  logic [TagW-1:0]   miss_tag_q, miss_tag_d;

  // Request decode
  logic [2:0]        req_word;
  logic [IndexW-1:0] req_idx;
  logic [TagW-1:0]   req_tag;
  logic              req;
  logic              hit;
  logic              wr_hit;
  logic [255:0]      hit_line;
  logic              unused_addr;

  assign req_word    = p1_addr_i[4:2];
  assign req_idx     = p1_addr_i[IndexW+OffsetW-1:OffsetW];
  assign req_tag     = p1_addr_i[31:IndexW+OffsetW];
  assign unused_addr = ^p1_addr_i[1:0];
  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign hit         = req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign hit_line    = data_q[req_idx];
  // A store wins when both requests are asserted
  assign wr_hit      = (state_q == StIdle) & hit & p1_MemWrite_i;

  // Line write port: refill in StFill, otherwise a merged word on a write hit
  logic              line_we;
  logic [IndexW-1:0] line_idx;
  logic [TagW-1:0]   line_wtag;
  logic [255:0]      line_wdata;

  // Select the line update source for this cycle
  always_comb begin
    line_we    = 1'b0;
    line_idx   = req_idx;
    line_wtag  = req_tag;
    line_wdata = hit_line;
    if (state_q == StFill) begin
      line_we    = 1'b1;
      line_idx   = miss_idx_q;
      line_wtag  = miss_tag_q;
      line_wdata = mem_data_i;
    end else if (wr_hit) begin
      line_we = 1'b1;
      line_wdata[{req_word, 5'b0} +: 32] = p1_data_i;
    end
  end

  // Line data and tag arrays; reset only touches valid/dirty
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      data_q[line_idx] <= line_wdata;
      tag_q[line_idx]  <= line_wtag;
    end
  end

  // Valid/dirty next state: write hit marks dirty, fill installs a clean line
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_hit) begin
      dirty_d[req_idx] = 1'b1;
    end
    if (state_q == StFill) begin
      valid_d[miss_idx_q] = 1'b1;
      dirty_d[miss_idx_q] = 1'b0;
    end
  end

  // State, metadata and miss-address registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  // Next-state logic; acks outside writeback/refill are ignored
  always_comb begin
    state_d    = state_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          miss_idx_d = req_idx;
          miss_tag_d = req_tag;
          state_d    = dirty_q[req_idx] ? StWriteback : StRefill;
        end
      end
      StWriteback: if (mem_ack_i) state_d = StRefill;
      StRefill:    if (mem_ack_i) state_d = StFill;
      StFill:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Outputs: memory request from state, CPU stall/data from hit logic
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      StWriteback: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, {OffsetW{1'b0}}};
        mem_data_o   = data_q[miss_idx_q];
      end
      StRefill: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, {OffsetW{1'b0}}};
      end
      default: ;
    endcase
    p1_stall_o = (state_q != StIdle) || (req && !hit);
    p1_data_o  = ((state_q == StIdle) && hit) ? hit_line[{req_word, 5'b0} +: 32] : 32'h0;
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: table of single-cycle hit vectors plus
// hand-written miss, writeback, write-allocate and reset-abort sequences.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  dcache_controller #(.NUM_LINES(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
    return l;
  endfunction

  task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = a;
    p1_data_i     = d;
  endtask

  // Serve one memory transaction: wait for enable, check it, hold, ack, then
  // for reads present the line in the cycle after the ack.
  task automatic mem_txn(input string name, input logic exp_wr, input logic [31:0] exp_addr,
                         input logic [255:0] rdata, output logic [255:0] wdata,
                         output int waited);
    logic [31:0] a0;
    waited = 0;
    #1;
    while (!mem_enable_o && waited < 20) begin
      @(negedge clk_i);
      #1;
      waited++;
    end
    chk({name, " enable seen"}, mem_enable_o, 1'b1);
    chk({name, " write flag"}, mem_write_o, exp_wr);
    chk({name, " addr"}, mem_addr_o, exp_addr);
    chk({name, " stall"}, p1_stall_o, 1'b1);
    a0    = mem_addr_o;
    wdata = mem_data_o;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      #1;
      chk({name, " hold"}, {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, exp_wr, a0});
      if (exp_wr) chk({name, " data hold"}, mem_data_o, wdata);
    end
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    if (!exp_wr) mem_data_i = rdata;
    #1;
  endtask

  vec_t         vecs [7];
  logic [255:0] wb;
  logic [255:0] exp_line;
  int           waited;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h44, 32'h0,          1'b0, 1'b1, 32'hA000_0001};
    vecs[1] = '{1'b1, 1'b0, 32'h5C, 32'h0,          1'b0, 1'b1, 32'hA000_0007};
    vecs[2] = '{1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF,  1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h44, 32'h0,          1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b1, 32'h48, 32'h1234_5678,  1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h48, 32'h0,          1'b0, 1'b1, 32'h1234_5678};
    vecs[6] = '{1'b1, 1'b0, 32'h4C, 32'h0,          1'b0, 1'b1, 32'hA000_0003};

    rst_i      = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst stall", p1_stall_o, 1'b0);
    chk("rst enable", mem_enable_o, 1'b0);
    chk("rst write", mem_write_o, 1'b0);
    chk("rst addr", mem_addr_o, 32'h0);
    chk("rst mem_data", mem_data_o, 256'h0);
    chk("rst p1_data", p1_data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Ack in idle is ignored
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("idle ack ignored", {mem_enable_o, p1_stall_o}, 2'b00);

    // Cold read miss on 0x40
    @(negedge clk_i);
    req(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("A miss stall", p1_stall_o, 1'b1);
    mem_txn("A refill", 1'b0, 32'h40, make_line(32'hA000_0000), wb, waited);
    chk("A fill enable", mem_enable_o, 1'b0);
    chk("A fill stall", p1_stall_o, 1'b1);
    @(negedge clk_i);
    #1;
    chk("A hit stall", p1_stall_o, 1'b0);
    chk("A hit data", p1_data_o, 32'hA000_0000);

    // Hit vectors on line 2
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("vec%0d stall", i), p1_stall_o, vecs[i].exp_stall);
      chk($sformatf("vec%0d enable", i), mem_enable_o, 1'b0);
      if (vecs[i].chk_data) chk($sformatf("vec%0d data", i), p1_data_o, vecs[i].exp_data);
    end

    // Conflict miss on dirty line 2: writeback 0x40 then refill 0x440
    @(negedge clk_i);
    req(1'b1, 1'b0, 32'h444, 32'h0);
    #1;
    chk("B miss stall", p1_stall_o, 1'b1);
    exp_line = make_line(32'hA000_0000);
    exp_line[63:32] = 32'hDEAD_BEEF;
    exp_line[95:64] = 32'h1234_5678;
    mem_txn("B wb", 1'b1, 32'h40, '0, wb, waited);
    chk("B wb word1", wb[63:32], 32'hDEAD_BEEF);
    chk("B wb line", wb, exp_line);
    mem_txn("B refill", 1'b0, 32'h440, make_line(32'hB000_0000), wb, waited);
    chk("B enable continuous", waited, 0);
    chk("B fill stall", {mem_enable_o, p1_stall_o}, 2'b01);
    @(negedge clk_i);
    #1;
    chk("B hit stall", p1_stall_o, 1'b0);
    chk("B hit data", p1_data_o, 32'hB000_0001);

    // Store miss on clean line 4: refill only, then write-allocate
    @(negedge clk_i);
    req(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D);
    #1;
    chk("C miss stall", p1_stall_o, 1'b1);
    mem_txn("C refill", 1'b0, 32'h80, make_line(32'hC000_0000), wb, waited);
    @(negedge clk_i);
    #1;
    chk("C store stall", p1_stall_o, 1'b0);
    @(negedge clk_i);
    req(1'b1, 1'b0, 32'h80, 32'h0);
    #1;
    chk("C read word0", p1_data_o, 32'hCAFE_F00D);
    @(negedge clk_i);
    req(1'b1, 1'b0, 32'h84, 32'h0);
    #1;
    chk("C read word1", p1_data_o, 32'hC000_0001);
    // Line 4 must now be dirty: a conflict forces a writeback
    @(negedge clk_i);
    req(1'b1, 1'b0, 32'h480, 32'h0);
    mem_txn("C wb", 1'b1, 32'h80, '0, wb, waited);
    chk("C wb word0", wb[31:0], 32'hCAFE_F00D);
    mem_txn("C2 refill", 1'b0, 32'h480, make_line(32'hD000_0000), wb, waited);
    @(negedge clk_i);
    #1;
    chk("C2 hit data", p1_data_o, 32'hD000_0000);

    // Dirty line 2 (tag 1), then abort its writeback with reset
    @(negedge clk_i);
    req(1'b0, 1'b1, 32'h440, 32'h1111_1111);
    #1;
    chk("D store stall", p1_stall_o, 1'b0);
    @(negedge clk_i);
    req(1'b1, 1'b0, 32'h40, 32'h0);
    waited = 0;
    #1;
    while (!mem_enable_o && waited < 20) begin
      @(negedge clk_i);
      #1;
      waited++;
    end
    chk("D wb start", {mem_enable_o, mem_write_o, mem_addr_o}, {2'b11, 32'h440});
    rst_i = 1'b0;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("D rst enable", mem_enable_o, 1'b0);
    chk("D rst write/addr", {mem_write_o, mem_addr_o}, 33'h0);
    chk("D rst stall", p1_stall_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    req(1'b1, 1'b0, 32'h44, 32'h0);
    #1;
    chk("D post-rst miss", p1_stall_o, 1'b1);
    mem_txn("D refill", 1'b0, 32'h40, make_line(32'hA000_0000), wb, waited);
    @(negedge clk_i);
    #1;
    chk("D hit data", p1_data_o, 32'hA000_0001);

    req(1'b0, 1'b0, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
